fft_stage_sequencer: RTL and testbench
======================================

# fft_stage_sequencer

Sequencer for the in-place radix-2 FFT datapath. On `start` it steps the butterfly counter and stage number through every FFT stage plus one write-drain stage, and drives the read/write enables, the memory bank select and completion status. Its `counter` and `stage_num` outputs feed the FFT address generator directly.

## Interface
- `NUMSTAGES`, default 5: log2 of the FFT length. Legal range 3..7. `counter` width is NUMSTAGES-2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin one transform; sampled only in IDLE.
- `hold`  in  1  stall request; used only with `FFT_SEQ_HOLD_EN` defined.
- `counter`  out  NUMSTAGES-2  butterfly index within the current stage.
- `stage_num`  out  3  current stage, 0..NUMSTAGES; NUMSTAGES is the drain stage.
- `rd_en`  out  1  read memory enable.
- `wr_en`  out  1  write memory enable; writes carry the previous stage's results.
- `bank_sel`  out  1  ping-pong bank select; equals `stage_num[0]` while busy.
- `stage_last`  out  1  high while `counter` is all ones and `busy` is high.
- `busy`  out  1  transform in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE.
- Reset drives the block to IDLE with all outputs zero: `counter`=0, `stage_num`=0, `rd_en`=0, `wr_en`=0, `bank_sel`=0, `stage_last`=0, `busy`=0, `done`=0.
- IDLE, `start`=1 -> RUN with `counter`=0, `stage_num`=0.
- RUN, per active cycle:
  - `counter` increments, wrapping at 2^(NUMSTAGES-2)-1.
  - On wrap, `stage_num` increments.
  - `rd_en` = (`stage_num` < NUMSTAGES).
  - `wr_en` = (`stage_num` != 0).
- RUN exit: at the wrap with `stage_num`==NUMSTAGES, go to DONE. Outputs then equal their reset values, except `done`=1.
- DONE -> IDLE unconditionally after 1 cycle.
- `start` is ignored in RUN and DONE; no queuing.
- Arithmetic: `counter` is modulo 2^(NUMSTAGES-2); `stage_num` is unsigned 3-bit and never exceeds NUMSTAGES.
- Reset mid-transform: abort immediately to IDLE. No `done` pulse.

## Timing
- `start` is high at edge k -> at k+1: `busy`=1, `rd_en`=1, `wr_en`=0, `counter`=0, `stage_num`=0.
- Each stage lasts exactly 2^(NUMSTAGES-2) active cycles.
- RUN length is (NUMSTAGES+1)·2^(NUMSTAGES-2) active cycles; 48 for NUMSTAGES=5.
- `done` is asserted in the cycle immediately after the last drain cycle; `busy` is already 0 in that cycle.
- Earliest restart: `start` sampled the cycle after `done`. Minimum start-to-start spacing is RUN length + 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `FFT_SEQ_HOLD_EN` defined:
  - In RUN, `hold`=1 freezes `counter`, `stage_num` and `bank_sel`, and forces `rd_en`=`wr_en`=0 on the next cycle.
  - `busy` stays 1 during the hold.
  - Release resumes at the frozen position.
  - `hold` has no effect in IDLE or DONE.
  - Held cycles do not count toward stage length.
- `FFT_SEQ_HOLD_EN` undefined: `hold` is ignored and no hold logic is synthesized.

## Test plan
- Reset, then `start` pulse, NUMSTAGES=5 -> `busy` is high for 48 cycles, with `stage_num` sequence 0×8, 1×8, …, 5×8. `counter` runs 0..7 each stage. `done` is high only on cycle 49.
- Same run, check enables -> `rd_en`=1 for cycles 1..40 and 0 for 41..48. `wr_en`=0 for cycles 1..8 and 1 for 9..48. `bank_sel` toggles every 8 cycles.
- `start` held high continuously -> back-to-back transforms with exactly one DONE cycle and one IDLE cycle between them (spacing 50). `start` pulses during RUN are ignored.
- `rst` asserted at cycle 20 of RUN -> all outputs are 0 asynchronously, no `done`. The next `start` begins at `stage_num`=0, `counter`=0.
- With `FFT_SEQ_HOLD_EN`: `hold`=1 for 3 cycles at `stage_num`=2, `counter`=5 -> both values are frozen and `rd_en`/`wr_en` are 0 during the hold. `done` arrives 3 cycles later than nominal (cycle 52).
- NUMSTAGES=3 -> stages 0..3 with `counter` 0..1. `busy` is high for 8 cycles, then `done`.

Source files
------------

// File: rtl/fft_stage_sequencer_if.sv
// Handshake/status bundle between the FFT controller and the stage sequencer.
// master: controller side (drives start/hold, observes status).
// slave : sequencer side.
interface fft_stage_sequencer_if #(
   parameter int NUMSTAGES = 5
);
   logic                   start;
   logic                   hold;
   logic [NUMSTAGES-3:0]   counter;
   logic [2:0]             stage_num;
   logic                   rd_en;
   logic                   wr_en;
   logic                   bank_sel;
   logic                   stage_last;
   logic                   busy;
   logic                   done;

   modport master (
      output start, hold,
      input  counter, stage_num, rd_en, wr_en, bank_sel, stage_last, busy, done
   );

   modport slave (
      input  start, hold,
      output counter, stage_num, rd_en, wr_en, bank_sel, stage_last, busy, done
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for an in-place radix-2 FFT.
// Walks the butterfly counter through NUMSTAGES compute stages plus one
// write-drain stage, driving read/write enables, ping-pong bank select and
// a one-cycle done pulse. Every output is a flop, so nothing is combinational
// from start/hold to the outputs.
// Optional feature macro: FFT_SEQ_HOLD_EN (stall via hold while running).
module fft_stage_sequencer #(
   parameter int NUMSTAGES = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   fft_stage_sequencer_if.slave    bus
);
   localparam int         CW         = NUMSTAGES - 2;
   localparam logic [2:0] LAST_STAGE = 3'(NUMSTAGES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   counter, counter_nxt;
   logic [2:0]      stage_num, stage_nxt;
   logic            rd_en, rd_nxt;
   logic            wr_en, wr_nxt;
   logic            bank_sel, bank_nxt;
   logic            stage_last, last_nxt;
   logic            busy, busy_nxt;
   logic            done, done_nxt;

   logic            hold_act;
   logic            wrap;

`ifdef FFT_SEQ_HOLD_EN
   // Stall request only matters while a transform is running.
   assign hold_act = bus.hold && (state == RUN);
`else
   assign hold_act = 1'b0;
`endif

   assign wrap = &counter;

   // Register state and all outputs; async reset returns to IDLE with zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         counter    <= '0;
         stage_num  <= '0;
         rd_en      <= 1'b0;
         wr_en      <= 1'b0;
         bank_sel   <= 1'b0;
         stage_last <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         counter    <= counter_nxt;
         stage_num  <= stage_nxt;
         rd_en      <= rd_nxt;
         wr_en      <= wr_nxt;
         bank_sel   <= bank_nxt;
         stage_last <= last_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   // Next-state and next-output decode. Outputs describe the position the
   // sequencer will occupy in the following cycle.
   always_comb begin
      state_nxt   = state;
      counter_nxt = '0;
      stage_nxt   = '0;
      rd_nxt      = 1'b0;
      wr_nxt      = 1'b0;
      busy_nxt    = 1'b0;
      done_nxt    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nxt = RUN;
               busy_nxt  = 1'b1;
               rd_nxt    = 1'b1;   // stage 0 reads, nothing to write back yet
            end
         end

         RUN: begin
            if (hold_act) begin
               // Freeze position; enables drop for the stalled cycle.
               counter_nxt = counter;
               stage_nxt   = stage_num;
               busy_nxt    = 1'b1;
            end else if (wrap && (stage_num == LAST_STAGE)) begin
               // End of drain stage: everything back to idle values.
               state_nxt = DONE;
               done_nxt  = 1'b1;
            end else begin
               counter_nxt = counter + CW'(1);
               stage_nxt   = wrap ? stage_num + 3'd1 : stage_num;
               busy_nxt    = 1'b1;
               rd_nxt      = (stage_nxt < LAST_STAGE);
               wr_nxt      = (stage_nxt != 3'd0);
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Bank follows stage parity while busy, frozen naturally during hold.
      bank_nxt = busy_nxt & stage_nxt[0];
      last_nxt = busy_nxt & (&counter_nxt);
   end

   // Drive the interface from the registered copies.
   assign bus.counter    = counter;
   assign bus.stage_num  = stage_num;
   assign bus.rd_en      = rd_en;
   assign bus.wr_en      = wr_en;
   assign bus.bank_sel   = bank_sel;
   assign bus.stage_last = stage_last;
   assign bus.busy       = busy;
   assign bus.done       = done;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer: directed scenarios plus a
// randomized start/hold/reset soak, each cycle compared to a position-based
// reference model (transform position p -> counter = p mod L, stage = p / L).
module tb_fft_stage_sequencer;
   localparam int NS      = 5;
   localparam int SL      = 1 << (NS - 2);     // cycles per stage
   localparam int RUN_LEN = (NS + 1) * SL;     // 48 for NS=5
`ifdef FFT_SEQ_HOLD_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   fft_stage_sequencer_if #(.NUMSTAGES(NS)) bus ();

   fft_stage_sequencer #(.NUMSTAGES(NS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: 0 idle, 1 run, 2 done
   int m_state = 0;
   int m_pos   = 0;
   bit m_held  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pos   = 0;
      m_held  = 1'b0;
   endtask

   task automatic model_step(input bit s, input bit h);
      case (m_state)
         0: if (s) begin m_state = 1; m_pos = 0; m_held = 1'b0; end
         1: begin
            if (HOLD_EN && h) m_held = 1'b1;
            else begin
               m_held = 1'b0;
               if (m_pos == RUN_LEN - 1) m_state = 2;
               else m_pos++;
            end
         end
         default: m_state = 0;
      endcase
   endtask

   task automatic compare_all();
      bit run;
      int cnt, stg;
      run = (m_state == 1);
      cnt = run ? (m_pos % SL) : 0;
      stg = run ? (m_pos / SL) : 0;
      chk("busy",       32'(bus.busy),       32'(run));
      chk("counter",    32'(bus.counter),    32'(cnt));
      chk("stage_num",  32'(bus.stage_num),  32'(stg));
      chk("rd_en",      32'(bus.rd_en),      32'(run && !m_held && stg < NS));
      chk("wr_en",      32'(bus.wr_en),      32'(run && !m_held && stg != 0));
      chk("bank_sel",   32'(bus.bank_sel),   32'(run && (stg % 2 == 1)));
      chk("stage_last", 32'(bus.stage_last), 32'(run && cnt == SL - 1));
      chk("done",       32'(bus.done),       32'(m_state == 2));
   endtask

   // One clock: drive inputs mid-cycle, step model on the edge, sample after.
   task automatic tick(input bit s, input bit h);
      @(negedge clk);
      bus.start = s;
      bus.hold  = h;
      @(posedge clk);
      model_step(s, h);
      #1 compare_all();
   endtask

   // Asynchronous reset asserted away from any clock edge.
   task automatic apply_reset();
      @(negedge clk);
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      #2 rst = 1'b1;
      #1 model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      #1 compare_all();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int busy_cnt, done_at;
      int rises[$];
      bit prev_busy;

      bus.start = 1'b0;
      bus.hold  = 1'b0;
      rst = 1'b1;
      #12;
      model_reset();
      compare_all();                  // reset state
      @(negedge clk);
      rst = 1'b0;

      // single start pulse: 48 busy cycles, done on cycle 49
      busy_cnt = 0;
      done_at  = 0;
      for (int c = 1; c <= 55; c++) begin
         tick(c == 1, 1'b0);
         if (bus.busy) busy_cnt++;
         if (bus.done && done_at == 0) done_at = c;
      end
      chk("busy_cycles", 32'(busy_cnt), 32'(RUN_LEN));
      chk("done_cycle",  32'(done_at),  32'(RUN_LEN + 1));

      // start held high: back-to-back transforms spaced RUN_LEN+2 apart
      prev_busy = bus.busy;
      for (int i = 1; i <= 130; i++) begin
         tick(1'b1, 1'b0);
         if (bus.busy && !prev_busy) rises.push_back(i);
         prev_busy = bus.busy;
      end
      chk("b2b_count", 32'(rises.size()), 32'd3);
      if (rises.size() >= 3) begin
         chk("b2b_space0", 32'(rises[1] - rises[0]), 32'(RUN_LEN + 2));
         chk("b2b_space1", 32'(rises[2] - rises[1]), 32'(RUN_LEN + 2));
      end

      // reset at cycle 20 of RUN, then restart from the beginning
      apply_reset();
      for (int c = 1; c <= 20; c++) tick(c == 1, 1'b0);
      apply_reset();
      done_at = 0;
      for (int c = 1; c <= 3; c++) begin
         tick(1'b0, 1'b0);
         if (bus.done) done_at = c;
      end
      chk("no_done_after_abort", 32'(done_at), 32'd0);
      tick(1'b1, 1'b0);
      chk("restart_counter", 32'(bus.counter),   32'd0);
      chk("restart_stage",   32'(bus.stage_num), 32'd0);
      chk("restart_busy",    32'(bus.busy),      32'd1);

`ifdef FFT_SEQ_HOLD_EN
      // hold 3 cycles at stage 2 / counter 5: done moves from 49 to 52
      apply_reset();
      done_at = 0;
      for (int c = 1; c <= 60; c++) begin
         tick(c == 1, (c >= 23 && c <= 25));
         if (c >= 23 && c <= 25) begin
            chk("hold_stage",   32'(bus.stage_num), 32'd2);
            chk("hold_counter", 32'(bus.counter),   32'd5);
            chk("hold_rd",      32'(bus.rd_en),     32'd0);
            chk("hold_wr",      32'(bus.wr_en),     32'd0);
         end
         if (bus.done && done_at == 0) done_at = c;
      end
      chk("hold_done_cycle", 32'(done_at), 32'(RUN_LEN + 4));
`endif

      // randomized soak: random start/hold with occasional async reset
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) apply_reset();
         else tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
